// File: rtl/div_sched_pkg.sv
// Shared types and default constants for the divider scheduler.
// The state encoding is common to the scheduler and any checker bound to it.
package div_sched_pkg;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_W       = 4;
  localparam int DEF_TIMEOUT = 31;

  // Wide enough for any supported operand width; users slice [W-1:0].
  localparam logic [63:0] DBZ_Q = {64{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
// Returns the winner both one-hot and encoded.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_sel,
  output logic [IDW-1:0]  o_idx
);

  logic [IDW-1:0]  w_ix [NREQ];
  logic [NREQ-1:0] w_hit;
  logic            w_found;

  // Walk the candidates in priority order; the first hit masks all later ones.
  always_comb begin
    o_sel   = '0;
    o_idx   = '0;
    w_hit   = '0;
    w_found = 1'b0;
    w_ix    = '{default: '0};
    for (int k = 0; k < NREQ; k++) begin
      w_ix[k]        = IDW'((int'(i_ptr) + k + 32'sd1) % NREQ);
      w_hit[k]       = ~w_found & i_req[w_ix[k]];
      o_sel[w_ix[k]] = o_sel[w_ix[k]] | w_hit[k];
      o_idx          = o_idx | (w_ix[k] & {IDW{w_hit[k]}});
      w_found        = w_found | w_hit[k];
    end
  end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider among NREQ requesters.
// Divide-by-zero is answered locally; a missing div_done is reported as a timeout.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_q,
  output logic [W:0]        rsp_r,
  output logic              rsp_dbz,
  output logic              rsp_tmo,
  output logic              div_start,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  input  logic              div_done,
  input  logic [W-1:0]      div_q,
  input  logic [W:0]        div_r
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic              r_busy;
  logic              r_rsp_valid;
  logic [IDW-1:0]    r_rsp_id;
  logic [W-1:0]      r_rsp_q;
  logic [W:0]        r_rsp_r;
  logic              r_rsp_dbz;
  logic              r_rsp_tmo;
  logic              r_div_start;
  logic [W-1:0]      r_div_a;
  logic [W-1:0]      r_div_b;

  logic [NREQ-1:0]   w_sel;
  logic [IDW-1:0]    w_idx;
  logic [W-1:0]      w_a;
  logic [W-1:0]      w_b;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_sel (w_sel),
    .o_idx (w_idx)
  );

  // Operand mux driven by the one-hot winner.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_a = w_a | (req_a[k*W +: W] & {W{w_sel[k]}});
      w_b = w_b | (req_b[k*W +: W] & {W{w_sel[k]}});
    end
  end

  // Scheduler FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_dbz   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_div_start <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
    end else begin
      r_gnt       <= '0;
      r_div_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state <= ST_GRANT;
            r_busy  <= 1'b1;
            r_gnt   <= w_sel;
            r_a     <= w_a;
            r_b     <= w_b;
            r_ptr   <= w_idx;
            r_id    <= w_idx;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (r_b == '0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_q     <= DBZ_Q[W-1:0];
            r_rsp_r     <= {1'b0, r_a};
            r_rsp_dbz   <= 1'b1;
            r_rsp_tmo   <= 1'b0;
          end else begin
            r_state     <= ST_ISSUE;
            r_div_start <= 1'b1;
            r_div_a     <= r_a;
            r_div_b     <= r_b;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          r_cnt   <= '0;
        end
        ST_WAIT: begin
          // A done in the final counted cycle still wins over the timeout.
          if (div_done) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_q     <= div_q;
            r_rsp_r     <= div_r;
            r_rsp_dbz   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_dbz   <= 1'b0;
            r_rsp_tmo   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_rsp_id  <= '0;
          r_rsp_q   <= '0;
          r_rsp_r   <= '0;
          r_rsp_dbz <= 1'b0;
          r_rsp_tmo <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign rsp_r     = r_rsp_r;
  assign rsp_dbz   = r_rsp_dbz;
  assign rsp_tmo   = r_rsp_tmo;
  assign div_start = r_div_start;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a behavioural divider whose done delay is programmable.
module tb_div_sched;
  import div_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int W = 4;
  localparam int TIMEOUT = 31;
  localparam int IDW = 1;
  localparam int NEVER = 1000;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_q;
  logic [W:0]        rsp_r;
  logic              rsp_dbz;
  logic              rsp_tmo;
  logic              div_start;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic              div_done;
  logic [W-1:0]      div_q;
  logic [W:0]        div_r;

  div_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz), .rsp_tmo(rsp_tmo),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  typedef struct {
    int id; int q; int r; int dbz; int tmo; int lat;
  } exp_t;
  typedef struct {
    int a; int b;
  } st_t;

  exp_t sb[$];
  st_t  st_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rsp = 0;
  int n_start = 0;
  int t_req = 0;
  int md_delay = 10;
  int md_cnt = 0;
  logic md_act = 1'b0;
  logic [W-1:0] md_a, md_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int id, input int q, input int r, input int dbz, input int tmo, input int lat);
    exp_t e;
    e.id = id; e.q = q; e.r = r; e.dbz = dbz; e.tmo = tmo; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic push_st(input int a, input int b);
    st_t s;
    s.a = a; s.b = b;
    st_q.push_back(s);
  endtask

  task automatic do_req(input int id, input int a, input int b);
    req_a[id*W +: W] = a[W-1:0];
    req_b[id*W +: W] = b[W-1:0];
    req[id] = 1'b1;
    t_req = cyc;
    for (int k = 0; k < 50 && gnt == '0; k++) @(negedge clk);
    chk("gnt", gnt, 32'(1) << id);
    chk("gnt_lat", cyc - t_req, 1);
    req[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 300 && n_rsp < target; k++) @(negedge clk);
    chk("rsp_wait", n_rsp >= target, 1);
    @(negedge clk);
  endtask

  // Cycle counter used for latency measurement.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural divider: done pulses md_delay+1 edges after start is observed.
  initial begin
    div_done = 1'b0;
    div_q = '0;
    div_r = '0;
    forever begin
      @(posedge clk);
      #1;
      div_done = 1'b0;
      if (md_act) begin
        md_cnt++;
        if (md_cnt == md_delay + 1) begin
          div_done = 1'b1;
          div_q = (md_b == '0) ? '1 : md_a / md_b;
          div_r = (md_b == '0) ? '0 : {1'b0, md_a % md_b};
          md_act = 1'b0;
        end
      end
      if (div_start) begin
        md_act = 1'b1;
        md_cnt = 0;
        md_a = div_a;
        md_b = div_b;
      end
    end
  end

  // Monitor: compares responses and divider starts against the scoreboards.
  initial forever begin
    @(negedge clk);
    if (rsp_valid) begin
      n_rsp++;
      chk("rsp_busy", busy, 1);
      if (sb.size() == 0) begin
        chk("rsp_unexp", rsp_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_q", rsp_q, e.q);
        chk("rsp_r", rsp_r, e.r);
        chk("rsp_dbz", rsp_dbz, e.dbz);
        chk("rsp_tmo", rsp_tmo, e.tmo);
        if (e.lat != 0) chk("rsp_lat", cyc - t_req, e.lat);
      end
    end
    if (div_start) begin
      n_start++;
      if (st_q.size() == 0) begin
        chk("start_unexp", div_start, 0);
      end else begin
        st_t s;
        s = st_q.pop_front();
        chk("div_a", div_a, s.a);
        chk("div_b", div_b, s.b);
      end
    end
  end

  initial begin
    int s0;
    int r0;
    rst_n = 1'b0;
    req = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {gnt, busy, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_tmo, div_start, div_a, div_b}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {gnt, busy, rsp_valid, div_start}, 0);

    // 1: single request 8/2
    push(0, 4, 0, 0, 0, 14);
    push_st(8, 2);
    do_req(0, 8, 2);
    wait_rsp(1);

    // 2: both held from reset, grants alternate 0,1,0,1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      push(0, 3, 1, 0, 0, 0);
      push_st(7, 2);
      push(1, 3, 2, 0, 0, 0);
      push_st(14, 4);
    end
    req_a = {4'd14, 4'd7};
    req_b = {4'd4, 4'd2};
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 100 && gnt == '0; j++) @(negedge clk);
      chk("rr_gnt", gnt, (k % 2 == 0) ? 1 : 2);
      if (k == 3) req = '0;
      @(negedge clk);
    end
    wait_rsp(5);

    // 3: divide by zero on requester 1
    s0 = n_start;
    push(1, 15, 9, 1, 0, 2);
    do_req(1, 9, 0);
    wait_rsp(6);
    chk("dbz_nostart", n_start, s0);

    // 4: divider never answers, then a normal request
    md_delay = NEVER;
    push(0, 0, 0, 0, 1, TIMEOUT + 4);
    push_st(5, 5);
    do_req(0, 5, 5);
    wait_rsp(7);
    md_delay = 10;
    push(0, 0, 3, 0, 0, 14);
    push_st(3, 7);
    do_req(0, 3, 7);
    wait_rsp(8);

    // 5: asynchronous reset in WAIT, late done must be ignored
    push_st(8, 2);
    do_req(0, 8, 2);
    repeat (4) @(negedge clk);
    chk("in_wait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("arst_outs", {gnt, busy, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_tmo, div_start, div_a, div_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = n_rsp;
    repeat (20) @(negedge clk);
    chk("late_done_ign", n_rsp, r0);
    chk("idle_after_rst", busy, 0);
    push(0, 4, 0, 0, 0, 14);
    push_st(8, 2);
    do_req(0, 8, 2);
    wait_rsp(9);

    // 6: done exactly on the timeout cycle, then one cycle too late
    md_delay = TIMEOUT;
    push(1, 2, 0, 0, 0, TIMEOUT + 4);
    push_st(6, 3);
    do_req(1, 6, 3);
    wait_rsp(10);
    md_delay = TIMEOUT + 1;
    push(0, 0, 0, 0, 1, TIMEOUT + 4);
    push_st(13, 4);
    do_req(0, 13, 4);
    wait_rsp(11);
    md_delay = 10;
    push(0, 3, 1, 0, 0, 14);
    push_st(13, 4);
    do_req(0, 13, 4);
    wait_rsp(12);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("st_empty", st_q.size(), 0);
    chk("end_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Round-robin scheduler that shares one iterative divider (module_divisor class, start/done handshake) between NREQ requesters.
- Grants one requester at a time and latches its operands.
- Sequences the divider with a start pulse, waits for done or timeout, and returns tagged quotient/remainder.
- Handles divide-by-zero locally without touching the divider. Sits between the input/keypad front-ends and the divider/7-seg path.

Parameters:
- NREQ, 2, number of requesters (2..4)
- W, 4, operand/quotient width
- TIMEOUT, 31, max cycles waited for div_done before error
- IDW, $clog2(NREQ), requester-id width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held until own gnt bit seen
- req_a  in  NREQ*W  dividends, slice i = requester i
- req_b  in  NREQ*W  divisors, slice i = requester i
- gnt  out  NREQ  one-hot, one-cycle pulse; operands of that requester sampled this cycle
- busy  out  1  high whenever state != IDLE
- rsp_valid  out  1  one-cycle result pulse (no backpressure)
- rsp_id  out  IDW  requester id of result
- rsp_q  out  W  quotient
- rsp_r  out  W+1  remainder (W+1 bits, matches divider R port)
- rsp_dbz  out  1  divide-by-zero flag, qualified by rsp_valid
- rsp_tmo  out  1  timeout flag, qualified by rsp_valid
- div_start  out  1  one-cycle start pulse to divider
- div_a  out  W  dividend to divider, stable from start until done
- div_b  out  W  divisor to divider, stable from start until done
- div_done  in  1  divider completion pulse
- div_q  in  W  divider quotient, valid with div_done
- div_r  in  W+1  divider remainder, valid with div_done

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low (rst_n).
- Reset values: all outputs 0. Internal state: state=IDLE, RR pointer=NREQ-1 (so requester 0 wins first), latched operands 0, timeout counter 0.
- All outputs are registered.
- FSM states: IDLE, GRANT, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, pick the first set bit searching from ptr+1 upward with wrap-around.
  - Next cycle is GRANT: gnt[sel]=1, a/b latched from slice sel, ptr<=sel, id<=sel.
- GRANT (1 cycle):
  - If latched b==0: go RESP with q=all ones, r={1'b0,a}, dbz=1; divider not started.
  - Otherwise go ISSUE.
- ISSUE (1 cycle): div_start=1, div_a/div_b driven from latches (held through WAIT), counter cleared. Go WAIT.
- WAIT:
  - Counter increments each cycle.
  - On div_done: latch div_q/div_r, go RESP.
  - If counter reaches TIMEOUT without done: go RESP with q=0, r=0, tmo=1.
  - div_done arriving in the same cycle the counter hits TIMEOUT: done wins.
- RESP (1 cycle): rsp_valid=1 with id/q/r/flags. Next state IDLE. Flags clear after the pulse.
- Latency:
  - Normal result: req seen in IDLE → gnt at +1, div_start at +2, rsp_valid one cycle after the cycle div_done is sampled.
  - Divide-by-zero: rsp_valid at +2.
- Fairness: a requester just served has lowest priority next arbitration. With all req held, grants rotate 0,1,…,NREQ-1,0.
- Requester rules:
  - Must keep req and operands stable until it sees its gnt bit.
  - Drops req the cycle after gnt, or keeps it high to request again; the scheduler re-arbitrates only in IDLE.
  - req changes outside IDLE are ignored.
- Stray div_done outside WAIT: ignored.
- Reset mid-operation: immediate return to reset values; divider is not flushed. A late div_done after reset is ignored because state is IDLE.
- Width rule: rsp_r is W+1 bits; the dbz remainder is zero-extended.

Decomposition:
- Package div_sched_pkg:
  - state enum (IDLE, GRANT, ISSUE, WAIT, RESP)
  - default W, NREQ, TIMEOUT constants
  - DBZ_Q constant (all ones)
- Sub-module rr_arbiter (NREQ parameter): inputs req, ptr; outputs one-hot sel and encoded index, combinational.
- Scheduler top holds the FSM, latches and timeout counter.

Test Plan (bench drives a behavioural divider that returns correct q/r after 10 cycles unless noted):
1. Req0 with 8/2 → gnt=01, div_start with div_a=8 div_b=2, rsp_valid with id=0 q=4 r=0, dbz=0 tmo=0.
2. Req0 and req1 simultaneous from reset, 7/2 and 14/4 held → req0 served first (q=3 r=1), then req1 (q=3 r=2). Repeat both held → order 0,1,0,1.
3. Req1 with 9/0 → no div_start, rsp_valid 2 cycles after req, id=1 q=15 r=9 dbz=1.
4. Divider model never asserts done, req0 5/5 → rsp_valid with tmo=1 q=0 r=0 after TIMEOUT+1 WAIT cycles. Next request (3/7) still served normally: q=0 r=3.
5. rst_n pulsed low while in WAIT → all outputs 0 asynchronously. Late div_done ignored, no rsp_valid. Fresh 8/2 request afterwards → q=4.
6. div_done coincident with TIMEOUT cycle → normal result returned, tmo=0.
